conv_input_framer: RTL and testbench
====================================

Name: conv_input_framer

Overview:
Upstream feeder for the convolutional encoder stage. It accepts parallel data words over a valid/ready handshake and serialises them into a one-bit-per-cycle stream with a per-bit strobe that drives the encoder's shift enable. At the end of each frame it appends SIZE_LENGTH-1 zero tail bits, so the encoder trellis returns to state 0 before the Viterbi decoder sees the next frame.

Parameters:
SIZE_IN, 8, input word width in bits.
SIZE_LENGTH, 3, encoder constraint length K. Tail length is K-1. Legal range is SIZE_LENGTH >= 2.
MSB_FIRST, 1, 1 sends bit SIZE_IN-1 first; 0 sends bit 0 first.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  upstream word valid.
i_data  input  SIZE_IN  upstream data word.
i_last  input  1  qualifies i_data as the final word of the frame.
o_ready  output  1  framer can accept a word this cycle.
i_ready  input  1  downstream (encoder) accepts o_bit this cycle.
o_bit  output  1  serial bit to the encoder.
o_bit_valid  output  1  o_bit is valid. Drives the encoder shift enable.
o_sof  output  1  o_bit is the first bit of a frame.
o_eof  output  1  o_bit is the last tail bit of a frame.
o_tail  output  1  o_bit is a tail (zero) bit.
o_busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE. Shift register, bit counter, tail counter, last flag and sof flag clear to 0.
  - All outputs read 0 except o_ready=1 (IDLE).
  - A partially sent word or frame is dropped. No tail is emitted.
- Transfer rules:
  - A word is accepted when i_valid && o_ready.
  - A bit is consumed when o_bit_valid && i_ready.
  - While o_bit_valid=1 and i_ready=0, o_bit, o_sof, o_eof and o_tail hold stable.
- FSM states:
  - IDLE: no frame open. o_ready=1, o_bit_valid=0. On accept: load the word into the shift register, set bit count to SIZE_IN-1, latch i_last, set the sof flag, go to SHIFT.
  - SHIFT: o_bit_valid=1. o_bit is the head bit of the register (MSB if MSB_FIRST, else LSB). o_sof = sof flag. On consume: shift, decrement count, clear the sof flag.
    - If count==0 on consume and the last flag is set: go to TAIL with tail count SIZE_LENGTH-2.
    - If count==0 on consume and the last flag is clear: if a new word is accepted in the same cycle, reload and stay in SHIFT with no bubble; otherwise go to WAIT.
  - WAIT: frame open, waiting for the next word. o_ready=1, o_bit_valid=0. On accept: load the word, go to SHIFT. The sof flag stays 0.
  - TAIL: o_bit=0, o_tail=1, o_bit_valid=1. On consume: decrement the tail count. When the tail count is 0: o_eof=1 on this bit and go to IDLE on consume. o_ready=0.
- o_ready = IDLE || WAIT || (SHIFT && count==0 && i_ready && !last flag).
  - This is a combinational path from i_ready to o_ready. It is documented and intended.
- Latency:
  - The first bit appears on o_bit the cycle after the word is accepted.
  - Continuous throughput is 1 bit/cycle while i_valid and i_ready stay high.
  - A frame of N words occupies N*SIZE_IN + SIZE_LENGTH-1 bit slots.
- i_data and i_last are sampled only on accept. i_valid with o_ready=0 has no effect.
- o_busy = (state != IDLE).

Test Plan:
- Single word: SIZE_IN=8, K=3, MSB_FIRST=1. Send 8'hA5 with i_last=1, i_ready=1 throughout.
  -> o_bit = 1,0,1,0,0,1,0,1,0,0 on 10 consecutive valid cycles. o_sof on bit 1 only. o_tail on bits 9-10. o_eof on bit 10 only. o_ready=1 again the following cycle.
- Back-to-back frame: send 8'h3C, then 8'hFF with i_last=1, both presented immediately.
  -> 18 contiguous valid bits: 0,0,1,1,1,1,0,0,1×8,0,0. o_ready pulses exactly on the cycle carrying bit 8 of the first word. No bubble, no second o_sof.
- Upstream gap: send 8'h3C, then delay the second word 3 cycles.
  -> FSM in WAIT. o_bit_valid=0 for 3 cycles. o_busy=1 throughout. o_sof does not reassert on the second word.
- Backpressure: drop i_ready for 2 cycles while bit 4 of 8'hA5 is presented.
  -> o_bit=0 and o_bit_valid=1 held for 2 cycles. The sequence resumes unchanged and the total bit count is still 10.
- Reset mid-frame: assert i_rst_n=0 during bit 5 of a frame.
  -> o_bit_valid, o_busy and o_tail go to 0 immediately. o_ready=1. After release, a new 8'h01 frame emits 0×7,1,0,0 with o_sof on bit 1.
- MSB_FIRST=0: send 8'h01 with i_last=1.
  -> o_bit = 1,0,0,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/conv_input_framer.sv
// Purpose : serialise parallel words into a 1-bit stream for the convolutional
//           encoder, appending SIZE_LENGTH-1 zero tail bits after each frame.
// Latency : first bit appears the cycle after a word is accepted; 1 bit/cycle sustained.
// Backpressure: i_ready low freezes o_bit/o_sof/o_eof/o_tail; o_ready combinationally
//           follows i_ready on the final bit of a non-last word so reloads have no bubble.
//
// Ports:
//   i_clk, i_rst_n            clock and asynchronous active-low reset
//   i_valid, i_data, i_last   upstream word handshake (o_ready back-channel)
//   o_bit, o_bit_valid        serial bit and encoder shift enable (i_ready back-channel)
//   o_sof, o_eof, o_tail      first data bit / last tail bit / tail-bit markers
//   o_busy                    frame open (not IDLE)
module conv_input_framer #(
  parameter int SIZE_IN     = 8,
  parameter int SIZE_LENGTH = 3,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [SIZE_IN-1:0] i_data,
  input  logic               i_last,
  output logic               o_ready,
  input  logic               i_ready,
  output logic               o_bit,
  output logic               o_bit_valid,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_tail,
  output logic               o_busy
);

  localparam int CW = (SIZE_IN > 1) ? $clog2(SIZE_IN) : 1;
  localparam int TW = (SIZE_LENGTH > 2) ? $clog2(SIZE_LENGTH - 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_TAIL  = 2'd3;

  localparam logic [CW-1:0] CNT_LOAD  = CW'(SIZE_IN - 1);
  localparam logic [TW-1:0] TAIL_LOAD = TW'(SIZE_LENGTH - 2);

  logic [1:0]         state_q, state_d;
  logic [SIZE_IN-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]      tail_cnt_q, tail_cnt_d;
  logic               last_q, last_d;
  logic               sof_q, sof_d;

  logic               head_bit;
  logic               last_data_bit;
  logic               accept;
  logic               consume;

  assign head_bit      = MSB_FIRST ? shreg_q[SIZE_IN-1] : shreg_q[0];
  assign last_data_bit = (state_q == ST_SHIFT) && (bit_cnt_q == '0);

  // The final data bit of a non-last word opens o_ready in the same cycle it is
  // consumed, so the next word reloads the register without an idle slot.
  assign o_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                   (last_data_bit && i_ready && !last_q);

  assign o_bit_valid = (state_q == ST_SHIFT) || (state_q == ST_TAIL);
  assign o_bit       = (state_q == ST_SHIFT) ? head_bit : 1'b0;
  assign o_sof       = (state_q == ST_SHIFT) && sof_q;
  assign o_tail      = (state_q == ST_TAIL);
  assign o_eof       = (state_q == ST_TAIL) && (tail_cnt_q == '0);
  assign o_busy      = (state_q != ST_IDLE);

  assign accept  = i_valid && o_ready;
  assign consume = o_bit_valid && i_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    last_d     = last_q;
    sof_d      = sof_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d   = i_data;
          bit_cnt_d = CNT_LOAD;
          last_d    = i_last;
          sof_d     = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (consume) begin
          shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          bit_cnt_d = bit_cnt_q - CW'(1);
          sof_d     = 1'b0;
          if (bit_cnt_q == '0) begin
            if (last_q) begin
              tail_cnt_d = TAIL_LOAD;
              state_d    = ST_TAIL;
            end else if (accept) begin
              shreg_d   = i_data;
              bit_cnt_d = CNT_LOAD;
              last_d    = i_last;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        if (accept) begin
          shreg_d   = i_data;
          bit_cnt_d = CNT_LOAD;
          last_d    = i_last;
          state_d   = ST_SHIFT;
        end
      end

      default: begin // ST_TAIL
        if (consume) begin
          if (tail_cnt_q == '0) begin
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q - TW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      last_q     <= 1'b0;
      sof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      last_q     <= last_d;
      sof_q      <= sof_d;
    end
  end

endmodule

// File: tb/tb_conv_input_framer.sv
module tb_conv_input_framer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       a_oready, a_bit, a_bvld, a_sof, a_eof, a_tail, a_busy;

  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       b_oready, b_bit, b_bvld, b_sof, b_eof, b_tail, b_busy;

  int vectors    = 0;
  int miscompares = 0;

  // Observation vector: {bit_valid, bit, sof, tail, eof, ready, busy}
  logic [6:0] obs_a, obs_b;
  assign obs_a = {a_bvld, a_bit, a_sof, a_tail, a_eof, a_oready, a_busy};
  assign obs_b = {b_bvld, b_bit, b_sof, b_tail, b_eof, b_oready, b_busy};

  localparam logic [6:0] IDLEV = 7'b0000010;
  localparam logic [6:0] WAITV = 7'b0000011;

  always #5 clk = ~clk;

  conv_input_framer #(.SIZE_IN(8), .SIZE_LENGTH(3), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(a_valid), .i_data(a_data), .i_last(a_last), .o_ready(a_oready),
    .i_ready(a_ready), .o_bit(a_bit), .o_bit_valid(a_bvld),
    .o_sof(a_sof), .o_eof(a_eof), .o_tail(a_tail), .o_busy(a_busy)
  );

  conv_input_framer #(.SIZE_IN(8), .SIZE_LENGTH(3), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(b_valid), .i_data(b_data), .i_last(b_last), .o_ready(b_oready),
    .i_ready(b_ready), .o_bit(b_bit), .o_bit_valid(b_bvld),
    .o_sof(b_sof), .o_eof(b_eof), .o_tail(b_tail), .o_busy(b_busy)
  );

  function automatic logic [6:0] bitv(input logic b, input logic sof, input logic rdy);
    return {1'b1, b, sof, 1'b0, 1'b0, rdy, 1'b1};
  endfunction

  function automatic logic [6:0] tailv(input logic eof);
    return {1'b1, 1'b0, 1'b0, 1'b1, eof, 1'b0, 1'b1};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Inputs are set at edge+1; outputs are compared at edge+2, then one clock passes.
  task automatic step_chk(input string tag, input int idx, input bit sel_b, input logic [6:0] exp);
    #1;
    chk(tag, idx, sel_b ? obs_b : obs_a, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;

    rst_n = 1'b0;
    a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0; a_ready = 1'b1;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0; b_ready = 1'b1;
    #12;
    chk("reset_a", 0, obs_a, IDLEV);
    chk("reset_b", 0, obs_b, IDLEV);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word A5, last
    a_valid = 1'b1; a_data = 8'hA5; a_last = 1'b1;
    step_chk("t1_accept", 0, 0, IDLEV);
    a_valid = 1'b0;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) step_chk("t1_bit", i, 0, bitv(w[7-i], i == 0, 1'b0));
    step_chk("t1_tail", 0, 0, tailv(1'b0));
    step_chk("t1_tail", 1, 0, tailv(1'b1));
    step_chk("t1_idle", 0, 0, IDLEV);

    // Back-to-back 3C then FF (last), no bubble
    a_valid = 1'b1; a_data = 8'h3C; a_last = 1'b0;
    step_chk("t2_accept", 0, 0, IDLEV);
    a_data = 8'hFF; a_last = 1'b1;
    w = 8'h3C;
    for (int i = 0; i < 8; i++) step_chk("t2_w0", i, 0, bitv(w[7-i], i == 0, i == 7));
    a_valid = 1'b0;
    w = 8'hFF;
    for (int i = 0; i < 8; i++) step_chk("t2_w1", i, 0, bitv(w[7-i], 1'b0, 1'b0));
    step_chk("t2_tail", 0, 0, tailv(1'b0));
    step_chk("t2_tail", 1, 0, tailv(1'b1));
    step_chk("t2_idle", 0, 0, IDLEV);

    // Upstream gap: 3C, three WAIT cycles, then 81 (last)
    a_valid = 1'b1; a_data = 8'h3C; a_last = 1'b0;
    step_chk("t3_accept", 0, 0, IDLEV);
    a_valid = 1'b0;
    w = 8'h3C;
    for (int i = 0; i < 8; i++) step_chk("t3_w0", i, 0, bitv(w[7-i], i == 0, i == 7));
    step_chk("t3_wait", 0, 0, WAITV);
    step_chk("t3_wait", 1, 0, WAITV);
    a_valid = 1'b1; a_data = 8'h81; a_last = 1'b1;
    step_chk("t3_wait", 2, 0, WAITV);
    a_valid = 1'b0;
    w = 8'h81;
    for (int i = 0; i < 8; i++) step_chk("t3_w1", i, 0, bitv(w[7-i], 1'b0, 1'b0));
    step_chk("t3_tail", 0, 0, tailv(1'b0));
    step_chk("t3_tail", 1, 0, tailv(1'b1));
    step_chk("t3_idle", 0, 0, IDLEV);

    // Backpressure on bit 4 of A5
    a_valid = 1'b1; a_data = 8'hA5; a_last = 1'b1;
    step_chk("t4_accept", 0, 0, IDLEV);
    a_valid = 1'b0;
    w = 8'hA5;
    for (int i = 0; i < 3; i++) step_chk("t4_bit", i, 0, bitv(w[7-i], i == 0, 1'b0));
    a_ready = 1'b0;
    step_chk("t4_hold", 0, 0, bitv(1'b0, 1'b0, 1'b0));
    step_chk("t4_hold", 1, 0, bitv(1'b0, 1'b0, 1'b0));
    a_ready = 1'b1;
    for (int i = 3; i < 8; i++) step_chk("t4_bit", i, 0, bitv(w[7-i], 1'b0, 1'b0));
    step_chk("t4_tail", 0, 0, tailv(1'b0));
    step_chk("t4_tail", 1, 0, tailv(1'b1));
    step_chk("t4_idle", 0, 0, IDLEV);

    // Reset during bit 5, then a fresh 01 frame
    a_valid = 1'b1; a_data = 8'hA5; a_last = 1'b1;
    step_chk("t5_accept", 0, 0, IDLEV);
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) step_chk("t5_bit", i, 0, bitv(w[7-i], i == 0, 1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_reset", 0, obs_a, IDLEV);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b1; a_data = 8'h01; a_last = 1'b1;
    step_chk("t5_accept", 1, 0, IDLEV);
    a_valid = 1'b0;
    w = 8'h01;
    for (int i = 0; i < 8; i++) step_chk("t5_w", i, 0, bitv(w[7-i], i == 0, 1'b0));
    step_chk("t5_tail", 0, 0, tailv(1'b0));
    step_chk("t5_tail", 1, 0, tailv(1'b1));
    step_chk("t5_idle", 0, 0, IDLEV);

    // LSB-first instance: 01 (last)
    b_valid = 1'b1; b_data = 8'h01; b_last = 1'b1;
    step_chk("t6_accept", 0, 1, IDLEV);
    b_valid = 1'b0;
    w = 8'h01;
    for (int i = 0; i < 8; i++) step_chk("t6_bit", i, 1, bitv(w[i], i == 0, 1'b0));
    step_chk("t6_tail", 0, 1, tailv(1'b0));
    step_chk("t6_tail", 1, 1, tailv(1'b1));
    step_chk("t6_idle", 0, 1, IDLEV);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
